// File: rtl/cpu64_cache_port_arb.sv
// N-port OBI arbiter in front of the L1 cache port.
// In-order response routing plus drain-then-pulse global invalidate.
module cpu64_cache_port_arb #(
    parameter int NUM_PORTS       = 3,
    parameter int MAX_OUTSTANDING = 4,
    parameter int ARB_MODE        = 1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NUM_PORTS-1:0]      req_i,
    input  logic [NUM_PORTS-1:0]      we_i,
    input  logic [8*NUM_PORTS-1:0]    be_i,
    input  logic [64*NUM_PORTS-1:0]   addr_i,
    input  logic [64*NUM_PORTS-1:0]   wdata_i,
    output logic [NUM_PORTS-1:0]      gnt_o,
    output logic [NUM_PORTS-1:0]      rvalid_o,
    output logic [63:0]               rdata_o,
    output logic                      req_o,
    output logic                      we_o,
    output logic [7:0]                be_o,
    output logic [63:0]               addr_o,
    output logic [63:0]               wdata_o,
    input  logic                      gnt_i,
    input  logic                      rvalid_i,
    input  logic [63:0]               rdata_i,
    input  logic                      inv_req_i,
    output logic                      invalidate_all_o,
    output logic                      inv_busy_o,
    output logic                      err_o
);

    localparam int IDW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int PW  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CW  = $clog2(MAX_OUTSTANDING + 1);

    localparam logic [CW-1:0]  CNT_MAX   = CW'(MAX_OUTSTANDING);
    localparam logic [PW-1:0]  PTR_LAST  = PW'(MAX_OUTSTANDING - 1);
    localparam logic [IDW-1:0] PORT_LAST = IDW'(NUM_PORTS - 1);

    typedef enum logic [1:0] {
        INV_IDLE,
        INV_DRAIN,
        INV_PULSE
    } inv_state_t;

    inv_state_t     inv_state_q;
    logic           busy_q;
    logic           pulse_q;
    logic           err_q;
    logic           lock_q;
    logic [IDW-1:0] lock_id_q;
    logic [IDW-1:0] last_ptr_q;
    logic [CW-1:0]  count_q;
    logic [PW-1:0]  rd_ptr_q;
    logic [PW-1:0]  wr_ptr_q;
    logic [IDW-1:0] fifo_q [MAX_OUTSTANDING];

    logic [IDW-1:0] arb_win;
    logic           arb_any;
    logic           issue;
    logic [IDW-1:0] win;
    logic           hs;
    logic           pop;
    logic [IDW-1:0] head;
    logic [CW-1:0]  count_d;
    logic           lock_d;
    int             idx;

    // Pick a winner: lowest index, or rotating from the last winner.
    always_comb begin
        arb_win = '0;
        arb_any = 1'b0;
        idx     = 0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (ARB_MODE == 0) begin
                idx = k;
            end else begin
                idx = int'(last_ptr_q) + k + 1;
                if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
            end
            if (!arb_any && req_i[IDW'(idx)]) begin
                arb_any = 1'b1;
                arb_win = IDW'(idx);
            end
        end
    end

    // A held request keeps its port; fresh ones are gated by room and FSM.
    always_comb begin
        issue   = arb_any && (count_q < CNT_MAX)
                  && (inv_state_q == INV_IDLE);
        req_o   = !rst_i && (lock_q || issue);
        win     = lock_q ? lock_id_q : arb_win;
        hs      = req_o && gnt_i;
        head    = fifo_q[rd_ptr_q];
        pop     = rvalid_i && (count_q != '0);
        lock_d  = req_o && !gnt_i;
        count_d = count_q;
        unique case ({hs, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Route the winner's fields down and grants/responses back up.
    always_comb begin
        we_o    = 1'b0;
        be_o    = '0;
        addr_o  = '0;
        wdata_o = '0;
        rdata_o = rdata_i;
        for (int p = 0; p < NUM_PORTS; p++) begin
            gnt_o[p]    = hs && (win == IDW'(p));
            rvalid_o[p] = !rst_i && pop && (head == IDW'(p));
            if (win == IDW'(p)) begin
                we_o    = we_i[p];
                be_o    = be_i[p*8 +: 8];
                addr_o  = addr_i[p*64 +: 64];
                wdata_o = wdata_i[p*64 +: 64];
            end
        end
    end

    // Lock, round-robin pointer, outstanding count and sticky error.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lock_q     <= 1'b0;
            lock_id_q  <= '0;
            last_ptr_q <= PORT_LAST;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            lock_q  <= lock_d;
            count_q <= count_d;
            if (lock_d) lock_id_q <= win;
            if (hs) begin
                last_ptr_q <= win;
                wr_ptr_q   <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
            end
            if (rvalid_i && (count_q == '0)) err_q <= 1'b1;
        end
    end

    // ID storage; contents are only meaningful below count_q.
    always_ff @(posedge clk_i) begin
        if (hs) fifo_q[wr_ptr_q] <= win;
    end

    // Invalidate sequencer: block issue, wait for empty, pulse once.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            inv_state_q <= INV_IDLE;
            busy_q      <= 1'b0;
            pulse_q     <= 1'b0;
        end else begin
            unique case (inv_state_q)
                INV_IDLE: begin
                    if (inv_req_i) begin
                        inv_state_q <= INV_DRAIN;
                        busy_q      <= 1'b1;
                    end
                end
                INV_DRAIN: begin
                    if (!lock_d && (count_d == '0)) begin
                        inv_state_q <= INV_PULSE;
                        pulse_q     <= 1'b1;
                    end
                end
                INV_PULSE: begin
                    inv_state_q <= INV_IDLE;
                    busy_q      <= 1'b0;
                    pulse_q     <= 1'b0;
                end
                default: begin
                    inv_state_q <= INV_IDLE;
                    busy_q      <= 1'b0;
                    pulse_q     <= 1'b0;
                end
            endcase
        end
    end

    assign invalidate_all_o = pulse_q && !rst_i;
    assign inv_busy_o       = busy_q && !rst_i;
    assign err_o            = err_q;

endmodule

// File: tb/tb_cpu64_cache_port_arb.sv
// Bench for cpu64_cache_port_arb: directed scenarios plus random traffic
// compared every cycle against a queue-based model of the arbiter.
module tb_cpu64_cache_port_arb;

    localparam int NP  = 3;
    localparam int MAX = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic [NP-1:0]     req_i, we_i;
    logic [8*NP-1:0]   be_i;
    logic [64*NP-1:0]  addr_i, wdata_i;
    logic              gnt_i, rvalid_i, inv_req_i;
    logic [63:0]       rdata_i;

    logic [NP-1:0]     gnt_o, rvalid_o;
    logic [63:0]       rdata_o, addr_o, wdata_o;
    logic              req_o, we_o, inv_o, busy_o, err_o;
    logic [7:0]        be_o;

    logic [NP-1:0]     f_gnt_o, f_rvalid_o;
    logic [63:0]       f_rdata_o, f_addr_o, f_wdata_o;
    logic              f_req_o, f_we_o, f_inv_o, f_busy_o, f_err_o;
    logic [7:0]        f_be_o;

    cpu64_cache_port_arb #(
        .NUM_PORTS(NP), .MAX_OUTSTANDING(MAX), .ARB_MODE(1)
    ) u_rr (
        .clk_i(clk), .rst_i(rst), .req_i(req_i), .we_i(we_i),
        .be_i(be_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
        .req_o(req_o), .we_o(we_o), .be_o(be_o), .addr_o(addr_o),
        .wdata_o(wdata_o), .gnt_i(gnt_i), .rvalid_i(rvalid_i),
        .rdata_i(rdata_i), .inv_req_i(inv_req_i),
        .invalidate_all_o(inv_o), .inv_busy_o(busy_o), .err_o(err_o)
    );

    cpu64_cache_port_arb #(
        .NUM_PORTS(NP), .MAX_OUTSTANDING(MAX), .ARB_MODE(0)
    ) u_fix (
        .clk_i(clk), .rst_i(rst), .req_i(req_i), .we_i(we_i),
        .be_i(be_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .gnt_o(f_gnt_o), .rvalid_o(f_rvalid_o), .rdata_o(f_rdata_o),
        .req_o(f_req_o), .we_o(f_we_o), .be_o(f_be_o), .addr_o(f_addr_o),
        .wdata_o(f_wdata_o), .gnt_i(gnt_i), .rvalid_i(rvalid_i),
        .rdata_i(rdata_i), .inv_req_i(inv_req_i),
        .invalidate_all_o(f_inv_o), .inv_busy_o(f_busy_o), .err_o(f_err_o)
    );

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got=%h expected=%h at %0t", name, got, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    int m_q[$];
    bit m_held = 1'b0;
    int m_hp = 0;
    int m_last = NP - 1;
    int m_ph = 0;
    bit m_err = 1'b0;

    int e_w, e_osz;
    bit e_req, e_hs;
    logic [NP-1:0] e_gnt, e_rv;

    function automatic int rr_pick(input logic [NP-1:0] r, input int last);
        for (int k = 1; k <= NP; k++)
            if (r[(last + k) % NP]) return (last + k) % NP;
        return 0;
    endfunction

    always @(negedge clk) begin
        e_osz = m_q.size();
        e_w = 0;
        e_req = 1'b0;
        if (!rst) begin
            if (m_held) begin
                e_req = 1'b1;
                e_w = m_hp;
            end else if (req_i != 0 && e_osz < MAX && m_ph == 0) begin
                e_req = 1'b1;
                e_w = rr_pick(req_i, m_last);
            end
        end
        e_hs  = e_req && gnt_i;
        e_gnt = e_hs ? NP'(1 << e_w) : '0;
        e_rv  = (!rst && rvalid_i && e_osz > 0) ? NP'(1 << m_q[0]) : '0;

        chk("m_req_o", req_o, e_req);
        chk("m_gnt_o", gnt_o, e_gnt);
        chk("m_rvalid_o", rvalid_o, e_rv);
        chk("m_rdata_o", rdata_o, rdata_i);
        chk("m_inv_o", inv_o, !rst && m_ph == 2);
        chk("m_busy_o", busy_o, !rst && m_ph != 0);
        chk("m_err_o", err_o, m_err);
        if (e_req) begin
            chk("m_addr_o", addr_o, addr_i[e_w*64 +: 64]);
            chk("m_wdata_o", wdata_o, wdata_i[e_w*64 +: 64]);
            chk("m_be_o", be_o, be_i[e_w*8 +: 8]);
            chk("m_we_o", we_o, we_i[e_w]);
        end

        if (rst) begin
            m_q.delete();
            m_held = 1'b0;
            m_last = NP - 1;
            m_ph = 0;
            m_err = 1'b0;
        end else begin
            if (rvalid_i && e_osz > 0) void'(m_q.pop_front());
            if (rvalid_i && e_osz == 0) m_err = 1'b1;
            if (e_hs) begin
                m_q.push_back(e_w);
                m_last = e_w;
            end
            m_held = e_req && !gnt_i;
            m_hp = e_w;
            case (m_ph)
                0: if (inv_req_i) m_ph = 1;
                1: if (!m_held && m_q.size() == 0) m_ph = 2;
                default: m_ph = 0;
            endcase
        end
    end

    // ---------------- stimulus ----------------
    localparam logic [63:0] A0 = 64'hAAAA_0000_0000_AAAA;
    localparam logic [63:0] A1 = 64'hBBBB_1111_1111_BBBB;
    localparam logic [63:0] A2 = 64'hCCCC_2222_2222_CCCC;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; req_i = 3'b111; we_i = 3'b010; be_i = 24'hF0_0F_FF;
        addr_i = {A2, A1, A0}; wdata_i = {~A2, ~A1, ~A0};
        gnt_i = 1'b1; rvalid_i = 1'b0; inv_req_i = 1'b0;
        rdata_i = 64'h1234_5678_9ABC_DEF0;

        tick(); #2;
        chk("rst_req_o", req_o, 0);
        chk("rst_gnt_o", gnt_o, 0);
        chk("rst_busy_o", busy_o, 0);
        tick(); #2;
        chk("rst_err_o", err_o, 0);

        // round-robin fairness / fixed priority
        tick(); rst = 1'b0; #2;
        chk("rr_gnt_first", gnt_o, 1);
        chk("fix_gnt_first", f_gnt_o, 1);
        for (int k = 1; k < 6; k++) begin
            tick(); rvalid_i = 1'b1; #2;
            chk("rr_gnt_seq", gnt_o, 64'd1 << (k % 3));
            chk("rr_rvalid_seq", rvalid_o, 64'd1 << ((k - 1) % 3));
            chk("fix_gnt_starve", f_gnt_o, 1);
            chk("fix_rvalid", f_rvalid_o, 1);
        end
        tick(); req_i = 3'b100; #2;
        chk("fix_gnt_release", f_gnt_o, 4);
        chk("rr_gnt_p2", gnt_o, 4);
        chk("rr_rvalid_p2", rvalid_o, 4);
        tick(); req_i = 3'b000; #2;
        chk("rr_rvalid_last", rvalid_o, 4);
        chk("idle_req_o", req_o, 0);

        // lock
        tick(); req_i = 3'b010; gnt_i = 1'b0; rvalid_i = 1'b0; #2;
        chk("lock_req_o", req_o, 1);
        chk("lock_addr_first", addr_o, A1);
        for (int k = 0; k < 2; k++) begin
            tick(); req_i = 3'b011; #2;
            chk("lock_addr_hold", addr_o, A1);
            chk("lock_no_gnt", gnt_o, 0);
        end
        tick(); gnt_i = 1'b1; #2;
        chk("lock_gnt_p1", gnt_o, 2);
        chk("fix_lock_gnt_p1", f_gnt_o, 2);
        tick(); req_i = 3'b000; gnt_i = 1'b0; rvalid_i = 1'b1; #2;
        chk("lock_rvalid_p1", rvalid_o, 2);

        // full
        for (int k = 0; k < 4; k++) begin
            tick(); rvalid_i = 1'b0; gnt_i = 1'b1; req_i = NP'(1 << (k % 3)); #2;
            chk("full_gnt", gnt_o, 64'd1 << (k % 3));
        end
        tick(); req_i = 3'b111; #2;
        chk("full_req_low", req_o, 0);
        chk("full_gnt_low", gnt_o, 0);
        tick(); rvalid_i = 1'b1; #2;
        chk("full_rvalid_oldest", rvalid_o, 1);
        chk("full_no_bypass", req_o, 0);
        tick(); rvalid_i = 1'b0; gnt_i = 1'b0; #2;
        chk("full_reassert", req_o, 1);
        tick(); req_i = 3'b000; gnt_i = 1'b1; #2;
        chk("full_locked_gnt", gnt_o, 2);
        tick(); gnt_i = 1'b0; rvalid_i = 1'b1; #2;
        chk("drain_rv0", rvalid_o, 2);
        tick(); #2; chk("drain_rv1", rvalid_o, 4);
        tick(); #2; chk("drain_rv2", rvalid_o, 1);
        tick(); #2; chk("drain_rv3", rvalid_o, 2);

        // invalidate with two outstanding
        tick(); rvalid_i = 1'b0; req_i = 3'b001; gnt_i = 1'b1;
        tick();
        tick(); req_i = 3'b000; inv_req_i = 1'b1; #2;
        chk("inv_pre_busy", busy_o, 0);
        tick(); inv_req_i = 1'b0; req_i = 3'b111; rvalid_i = 1'b1; #2;
        chk("inv_busy", busy_o, 1);
        chk("inv_block_req", req_o, 0);
        chk("inv_block_gnt", gnt_o, 0);
        chk("inv_drain_rv0", rvalid_o, 1);
        tick(); #2;
        chk("inv_no_pulse_yet", inv_o, 0);
        chk("inv_drain_rv1", rvalid_o, 1);
        tick(); rvalid_i = 1'b0; #2;
        chk("inv_pulse", inv_o, 1);
        chk("inv_pulse_no_gnt", gnt_o, 0);
        tick(); req_i = 3'b000; #2;
        chk("inv_pulse_end", inv_o, 0);
        chk("inv_busy_end", busy_o, 0);

        // invalidate latency with nothing outstanding
        tick(); inv_req_i = 1'b1;
        tick(); inv_req_i = 1'b0; #2;
        chk("lat_drain", inv_o, 0);
        chk("lat_busy", busy_o, 1);
        tick(); #2;
        chk("lat_pulse", inv_o, 1);
        tick(); #2;
        chk("lat_idle", busy_o, 0);

        // stray response, reset, pre-reset response
        tick(); rvalid_i = 1'b1; #2;
        chk("stray_no_rvalid", rvalid_o, 0);
        chk("stray_err_before", err_o, 0);
        tick(); rvalid_i = 1'b0; #2;
        chk("stray_err", err_o, 1);
        tick(); req_i = 3'b001; gnt_i = 1'b1;
        tick(); req_i = 3'b000; rst = 1'b1; #2;
        chk("rst_gnt_forced", gnt_o, 0);
        tick(); rst = 1'b0; #2;
        chk("rst_err_clr", err_o, 0);
        tick(); rvalid_i = 1'b1; #2;
        chk("post_rst_rvalid", rvalid_o, 0);
        tick(); rvalid_i = 1'b0; #2;
        chk("post_rst_err", err_o, 1);
        tick(); rst = 1'b1;
        tick(); rst = 1'b0;

        // random traffic against the model
        for (int i = 0; i < 4000; i++) begin
            tick();
            rst = ($urandom_range(0, 299) == 0);
            req_i = ($urandom_range(0, 4) == 0) ? '0 : NP'($urandom_range(0, 7));
            we_i = NP'($urandom_range(0, 7));
            be_i = 24'($urandom);
            for (int p = 0; p < NP; p++) begin
                addr_i[p*64 +: 64] = {$urandom, $urandom};
                wdata_i[p*64 +: 64] = {$urandom, $urandom};
            end
            gnt_i = ($urandom_range(0, 3) != 0);
            rvalid_i = (m_q.size() > 0 && $urandom_range(0, 2) != 0)
                       || ($urandom_range(0, 99) == 0);
            rdata_i = {$urandom, $urandom};
            inv_req_i = ($urandom_range(0, 39) == 0);
        end

        tick();
        rst = 1'b0; req_i = '0; rvalid_i = 1'b0; inv_req_i = 1'b0;
        tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/cpu64_cache_port_arb.md
# cpu64_cache_port_arb

Parametrised N-port OBI arbiter placed in front of the L1 side of the cache stack, so several requestors share one cache port: instruction fetch, data load/store and page-table walker. Requestor count, outstanding-response depth and arbitration mode are set by parameters. It tracks in-order responses and routes each `rvalid_i` back to the requestor that issued it. It also sequences a global invalidate: new requests are held off, outstanding responses drain, and then a single clean `invalidate_all_o` pulse goes to the cache stack.

## Interface
- `NUM_PORTS`, 3, number of upstream requestors (≥2).
- `MAX_OUTSTANDING`, 4, depth of the response-tracking FIFO (power of 2, ≥1).
- `ARB_MODE`, 1, 0 = fixed priority (lowest index wins), 1 = round-robin.
- `clk_i` in 1: the single clock.
- `rst_i` in 1: synchronous, active-high reset.
- `req_i` in NUM_PORTS: per-port OBI request.
- `we_i` in NUM_PORTS: per-port write enable.
- `be_i` in 8*NUM_PORTS: byte enables; port p uses bits [8p+7:8p].
- `addr_i` in 64*NUM_PORTS: addresses; port p uses bits [64p+63:64p].
- `wdata_i` in 64*NUM_PORTS: write data, packed the same way.
- `gnt_o` out NUM_PORTS: per-port grant, at most one bit set.
- `rvalid_o` out NUM_PORTS: per-port response valid, at most one bit set.
- `rdata_o` out 64: response data, broadcast to all ports.
- `req_o`, `we_o` out 1: downstream OBI request and write enable.
- `be_o` out 8, `addr_o` out 64, `wdata_o` out 64: downstream OBI fields.
- `gnt_i`, `rvalid_i` in 1: downstream grant and response valid.
- `rdata_i` in 64: downstream response data.
- `inv_req_i` in 1: request a global invalidate.
- `invalidate_all_o` out 1: one-cycle invalidate pulse to the cache stack.
- `inv_busy_o` out 1: high while the invalidate sequence is active.
- `err_o` out 1: sticky flag, set on `rvalid_i` with no outstanding entry.

## Operation
- **Arbitration**
  - A winner is chosen each cycle among the set `req_i` bits.
  - Fixed mode: the lowest index wins.
  - Round-robin mode: the search starts at `last_ptr+1` and wraps at NUM_PORTS.
  - `last_ptr` updates to the winner on each downstream handshake (`req_o && gnt_i`).
- **Request lock (OBI stability)**
  - Once `req_o` is asserted without `gnt_i`, the winner is locked in a register.
  - `req_o` and the muxed fields stay sourced from the locked port until `gnt_i`.
  - No re-arbitration happens while locked.
- **Issue gating**: a new (unlocked) `req_o` is asserted only when all of these hold:
  - some `req_i` bit is set;
  - `count < MAX_OUTSTANDING`;
  - the invalidate FSM is in IDLE.
  - A locked request is always kept asserted until granted, even if one of these conditions later fails.
- **Grant**: `gnt_o[winner] = req_o && gnt_i`. All other `gnt_o` bits are 0.
- **Response tracking**
  - On each handshake, the winner index is pushed into an in-order ID FIFO.
  - On `rvalid_i`, the FIFO head is popped and `rvalid_o[head] = 1`; `rdata_o = rdata_i`.
  - Push and pop in the same cycle leave `count` unchanged.
  - Full gating uses the registered `count`; there is no bypass on a same-cycle pop.
- **Stray response**
  - `rvalid_i` with `count == 0` drives no `rvalid_o` bit.
  - It sets `err_o`, which stays set until reset.
- **Invalidate FSM**, states IDLE → DRAIN → PULSE → IDLE:
  - IDLE: `inv_req_i` moves the FSM to DRAIN.
  - DRAIN: new arbitration is blocked. When no lock is held and `count == 0`, go to PULSE.
  - PULSE: `invalidate_all_o = 1` for exactly one cycle, then return to IDLE.
  - `inv_busy_o = (state != IDLE)`.
  - `inv_req_i` is ignored outside IDLE.
  - If `inv_req_i` is still high on the return to IDLE, a new sequence starts.

## Timing
- Reset (`rst_i` sampled high at a clock edge):
  - `count` is cleared to 0 and the FIFO is emptied.
  - The lock is cleared.
  - `last_ptr` is set to NUM_PORTS-1, so port 0 is first in round-robin.
  - The FSM goes to IDLE and `err_o` is cleared.
- While `rst_i` is high, these outputs are forced to 0: `req_o`, `gnt_o`, `rvalid_o`, `invalidate_all_o`, `inv_busy_o`.
- Reset mid-operation discards all outstanding entries. A `rvalid_i` arriving after reset for a pre-reset request sets `err_o`.
- Combinational paths (zero added latency):
  - `req_o` and the muxed fields follow `req_i` in the same cycle;
  - `gnt_o` follows `gnt_i` in the same cycle;
  - `rvalid_o` and `rdata_o` follow `rvalid_i` and `rdata_i` in the same cycle.
- Invalidate latency: from `inv_req_i` sampled in IDLE, when nothing is outstanding and no lock is held, `invalidate_all_o` is high 2 cycles later (DRAIN for 1 cycle, then PULSE).
- Throughput: one handshake per cycle when `gnt_i` is held high and `count` stays below `MAX_OUTSTANDING`.

## Test plan
- **Round-robin fairness**
  - Stimulus: ARB_MODE=1; all 3 ports request continuously; `gnt_i`=1; `rvalid_i` returned 1 cycle after each grant.
  - Required: grants in order 0,1,2,0,1,2; each `rvalid_o` matches the granting port.
- **Fixed priority**
  - Stimulus: ARB_MODE=0; ports 0 and 2 request.
  - Required: port 0 is granted every cycle and port 2 is starved until port 0 drops `req_i`.
- **Lock**
  - Stimulus: port 1 wins with `gnt_i`=0 for 3 cycles while port 0 also requests.
  - Required: `addr_o` stays at port 1's address; the first grant goes to port 1.
- **Full**
  - Stimulus: MAX_OUTSTANDING=4; 4 handshakes with no `rvalid_i`.
  - Required: `req_o`=0 on the next cycle. One `rvalid_i` goes to the oldest requestor, and `req_o` reasserts on the following cycle.
- **Invalidate with drain**
  - Stimulus: 2 responses outstanding when `inv_req_i` pulses.
  - Required: `inv_busy_o`=1; no new grants. `invalidate_all_o` pulses for 1 cycle, on the cycle after the second `rvalid_i`.
- **Stray response and reset**
  - Stimulus: `rvalid_i` with `count` = 0.
  - Required: `err_o`=1 and all `rvalid_o`=0. Asserting `rst_i` clears `err_o` and `count`.
